// File: rtl/line_write_buffer.sv
// rtl/line_write_buffer.sv - coalescing line write buffer between a cache and main memory
// Optional macro WBUF_FORWARD_EN: serve read hits from buffered lines instead of draining first.
module line_write_buffer #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int DEPTH         = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_LEN-1:0]                 addr,
    input  logic                                rd_req,
    input  logic                                wr_req,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    rd_line,
    output logic                                gnt,
    output logic [ADDR_LEN-1:0]                 mem_addr,
    output logic                                mem_rd_req,
    output logic                                mem_wr_req,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    mem_wr_line,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    mem_rd_line,
    input  logic                                mem_gnt
);
    localparam int LW    = 32 * (2 ** LINE_ADDR_LEN);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, FETCH, RESP} state_t;

    state_t state_q, state_d;

    logic                valid_q [DEPTH];
    logic [ADDR_LEN-1:0] addr_q  [DEPTH];
    logic [LW-1:0]       line_q  [DEPTH];
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [PTR_W:0]      count_q;

    logic             hit;
    logic [PTR_W-1:0] hit_idx;
    logic             do_enq, do_coalesce, do_fwd, do_drain_done, do_fetch_done;

    // Writes coalesce, so at most one valid entry can carry a given address.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == addr) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        do_enq        = 1'b0;
        do_coalesce   = 1'b0;
        do_fwd        = 1'b0;
        do_drain_done = 1'b0;
        do_fetch_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
`ifdef WBUF_FORWARD_EN
                    if (hit) begin
                        do_fwd  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = FETCH;
                    end
`else
                    // A stale memory copy must not be fetched while a newer line is buffered.
                    state_d = hit ? DRAIN : FETCH;
`endif
                end else if (wr_req) begin
                    if (hit) begin
                        do_coalesce = 1'b1;
                        state_d     = RESP;
                    end else if (count_q != FULL_COUNT) begin
                        do_enq  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_gnt) begin
                    do_drain_done = 1'b1;
                    state_d       = IDLE;
                end
            end
            FETCH: begin
                if (mem_gnt) begin
                    do_fetch_done = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt         = (state_q == RESP);
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        case (state_q)
            DRAIN: begin
                mem_wr_req  = 1'b1;
                mem_addr    = addr_q[head_q];
                mem_wr_line = line_q[head_q];
            end
            FETCH: begin
                mem_rd_req = 1'b1;
                mem_addr   = addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rd_line <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                line_q[i]  <= '0;
            end
        end else begin
            if (do_enq) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= addr;
                line_q[tail_q]  <= wr_line;
                tail_q          <= tail_q + 1'b1;
                count_q         <= count_q + 1'b1;
            end
            if (do_coalesce) begin
                line_q[hit_idx] <= wr_line;
            end
            if (do_drain_done) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
                count_q         <= count_q - 1'b1;
            end
            if (do_fwd) begin
                rd_line <= line_q[hit_idx];
            end
            if (do_fetch_done) begin
                rd_line <= mem_rd_line;
            end
        end
    end
endmodule
